rf_wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback and the long-latency unit (LU: multiply/divide, late loads). It sits between the WB stage and the register file and drives the port, so the same write also feeds the forwarding unit. LU results are buffered in a small FIFO and written in cycles where the pipeline does not write. A starvation counter requests a pipeline bubble so LU results always drain.

---
 rtl/rf_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// in-order WB stage and the long-latency unit (LU).
//
// The pipeline always wins the port. LU results wait in a small FIFO and are
// written in cycles where the pipeline does not write. A pipeline write kills
// any buffered LU result headed for the same register (WAW). A starvation
// counter raises bubble_req so buffered LU results always drain.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   pipe_we/waddr/wdata   WB-stage write request
//   lu_valid/waddr/wdata  LU result offer; lu_ready = FIFO not full
//   bubble_req       registered request for one WB bubble
//   rf_we/waddr/wdata     register-file write port (also feeds forwarding)
//   lu_grant         current write comes from the FIFO head
//   fifo_count       occupied FIFO entries
module rf_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_waddr,
    input  logic [XLEN-1:0]               pipe_wdata,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_waddr,
    input  logic [XLEN-1:0]               lu_wdata,
    output logic                          bubble_req,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          lu_grant,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // FIFO storage and pointers
    logic            live_q [FIFO_DEPTH];
    logic            live_d [FIFO_DEPTH];
    logic [4:0]      addr_q [FIFO_DEPTH];
    logic [4:0]      addr_d [FIFO_DEPTH];
    logic [XLEN-1:0] data_q [FIFO_DEPTH];
    logic [XLEN-1:0] data_d [FIFO_DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [SW-1:0]   starve_q, starve_d;
    state_t          state_q,  state_d;

    logic            pipe_eff;
    logic            fifo_empty;
    logic            head_live;
    logic            grant;
    logic            push;
    logic            pop;
    logic            ready_int;

    // Port arbitration and FIFO handshake decode
    always_comb begin
        pipe_eff   = pipe_we && (pipe_waddr != 5'd0);
        fifo_empty = (count_q == '0);
        head_live  = !fifo_empty && live_q[rd_ptr_q];
        grant      = head_live && !pipe_eff;
        // A dead head leaves on its own, independent of the port.
        pop        = !fifo_empty && (!live_q[rd_ptr_q] || grant);
        // Ready comes from the registered count only, so a pop while full
        // frees the slot for the next cycle, not this one.
        ready_int  = !rst && (count_q != FULL_CNT);
        push       = lu_valid && ready_int;
    end

    // Register-file port; held at zero for the whole time rst is high
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
        lu_grant = 1'b0;
        if (!rst) begin
            if (pipe_eff) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[rd_ptr_q];
                rf_wdata = data_q[rd_ptr_q];
                lu_grant = 1'b1;
            end
        end
    end

    // FIFO next state: WAW kill on resident entries, then push overlay
    always_comb begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            live_d[i] = live_q[i] && !(pipe_eff && (addr_q[i] == pipe_waddr));
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
        end
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        // The pushed slot is not resident, so the overlay also shields the
        // new entry from a same-cycle kill.
        if (push) begin
            live_d[wr_ptr_q] = (lu_waddr != 5'd0);
            addr_d[wr_ptr_q] = lu_waddr;
            data_d[wr_ptr_q] = lu_wdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Starvation counter: counts denied cycles of a live head, saturating
    always_comb begin
        starve_d = '0;
        if (head_live && !grant) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end
    end

    // Bubble request FSM: next state and output
    always_comb begin
        state_d    = state_q;
        bubble_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (starve_d == STARVE_MAX) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bubble_req = 1'b1;
                if (grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs from registered state
    always_comb begin
        lu_ready   = ready_int;
        fifo_count = count_q;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                live_q[i] <= 1'b0;
                addr_q[i] <= 5'd0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                live_q[i] <= live_d[i];
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter (XLEN=32, depth 2, limit 4).
// Each table row is one clock cycle: inputs driven just after the rising
// edge, all outputs compared mid-cycle against hand-computed values.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        bubble_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lu_grant;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(
        .XLEN         (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .bubble_req (bubble_req),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .lu_grant   (lu_grant),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gr;
        logic [1:0]  cnt;
        logic        rdy;
        logic        bub;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic gr, input logic [1:0] cnt, input logic rdy, input logic bub);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.lv = lv;   v.la = la; v.ld = ld;
        v.we = we;   v.wa = wa; v.wd = wd;
        v.gr = gr;   v.cnt = cnt; v.rdy = rdy; v.bub = bub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic gr, input logic [1:0] cnt,
                           input logic rdy, input logic bub);
        chk({tag, ".rf_we"},      32'(rf_we),      32'(we));
        chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(wa));
        chk({tag, ".rf_wdata"},   rf_wdata,        wd);
        chk({tag, ".lu_grant"},   32'(lu_grant),   32'(gr));
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, ".lu_ready"},   32'(lu_ready),   32'(rdy));
        chk({tag, ".bubble_req"}, 32'(bubble_req), 32'(bub));
    endtask

    initial begin
        //            pwe pa     pd            lv la     ld            we wa     wd            gr cnt rdy bub
        // idle port: push x5, written next cycle, then empty
        vecs[0]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 0, 1, 0);
        vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 1, 1, 1, 0);
        vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 1, 0);
        // priority: pipe x7 beats buffered x6, x6 written on next free cycle
        vecs[3]  = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h11,       0, 5'd0,  32'h0,        0, 0, 1, 0);
        vecs[4]  = mk(1, 5'd7,  32'h22,       0, 5'd0,  32'h0,        1, 5'd7,  32'h22,       0, 1, 1, 0);
        vecs[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd6,  32'h11,       1, 1, 1, 0);
        vecs[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 1, 0);
        // x0: pipe write to x0 frees the port; LU result to x0 never writes
        vecs[7]  = mk(0, 5'd0,  32'h0,        1, 5'd3,  32'h33,       0, 5'd0,  32'h0,        0, 0, 1, 0);
        vecs[8]  = mk(1, 5'd0,  32'h99,       0, 5'd0,  32'h0,        1, 5'd3,  32'h33,       1, 1, 1, 0);
        vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h44,       0, 5'd0,  32'h0,        0, 0, 1, 0);
        vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 0);
        vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 1, 0);
        // WAW kill: pipe x8 kills buffered x8, which then pops silently
        vecs[12] = mk(0, 5'd0,  32'h0,        1, 5'd8,  32'hAA,       0, 5'd0,  32'h0,        0, 0, 1, 0);
        vecs[13] = mk(1, 5'd8,  32'hBB,       0, 5'd0,  32'h0,        1, 5'd8,  32'hBB,       0, 1, 1, 0);
        vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 0);
        vecs[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 1, 0);
        // full/backpressure: pipe writes every cycle, bubble on 5th denial
        vecs[16] = mk(1, 5'd1,  32'h100,      1, 5'd9,  32'h90,       1, 5'd1,  32'h100,      0, 0, 1, 0);
        vecs[17] = mk(1, 5'd1,  32'h101,      1, 5'd10, 32'hA0,       1, 5'd1,  32'h101,      0, 1, 1, 0);
        vecs[18] = mk(1, 5'd1,  32'h102,      1, 5'd11, 32'hB0,       1, 5'd1,  32'h102,      0, 2, 0, 0);
        vecs[19] = mk(1, 5'd1,  32'h103,      0, 5'd0,  32'h0,        1, 5'd1,  32'h103,      0, 2, 0, 0);
        vecs[20] = mk(1, 5'd1,  32'h104,      0, 5'd0,  32'h0,        1, 5'd1,  32'h104,      0, 2, 0, 0);
        vecs[21] = mk(1, 5'd1,  32'h105,      0, 5'd0,  32'h0,        1, 5'd1,  32'h105,      0, 2, 0, 1);
        vecs[22] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  32'h90,       1, 2, 0, 1);
        vecs[23] = mk(1, 5'd1,  32'h106,      0, 5'd0,  32'h0,        1, 5'd1,  32'h106,      0, 1, 1, 0);
        // refill to count=2 with bubble_req=1 ahead of the reset test
        vecs[24] = mk(1, 5'd1,  32'h107,      1, 5'd12, 32'hC0,       1, 5'd1,  32'h107,      0, 1, 1, 0);
        vecs[25] = mk(1, 5'd1,  32'h108,      0, 5'd0,  32'h0,        1, 5'd1,  32'h108,      0, 2, 0, 0);
        vecs[26] = mk(1, 5'd1,  32'h109,      0, 5'd0,  32'h0,        1, 5'd1,  32'h109,      0, 2, 0, 0);
        vecs[27] = mk(1, 5'd1,  32'h10A,      0, 5'd0,  32'h0,        1, 5'd1,  32'h10A,      0, 2, 0, 1);

        // Reset held with active-looking inputs: everything must read as reset
        rst = 1'b1;
        drive(1, 5'd5, 32'h1234, 1, 5'd4, 32'h5678);
        #2;
        chk_all("rst0", 0, 5'd0, 32'h0, 0, 2'd0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk_all("rst1", 0, 5'd0, 32'h0, 0, 2'd0, 0, 0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
            #3;
            chk_all($sformatf("row%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].gr, vecs[i].cnt, vecs[i].rdy, vecs[i].bub);
        end

        // Async reset mid-drain, asserted between edges with pipe still writing
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 5'd0, 32'h0, 0, 2'd0, 0, 0);
        @(posedge clk);
        #2;
        chk_all("rst_hold", 0, 5'd0, 32'h0, 0, 2'd0, 0, 0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        chk_all("rst_rel", 0, 5'd0, 32'h0, 0, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #4;
            chk_all($sformatf("post_rst%0d", i), 0, 5'd0, 32'h0, 0, 2'd0, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
